mem_access: RTL
===============

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-002 SHALL have ports: wd_i in 5, wreg_i in 1, wdata_i in 32, hi_i in 32, lo_i in 32, whilo_i in 1, aluop_i in 8, mem_addr_i in 32, reg2_i in 32: instruction fields from the EX/MEM register.
REQ-003 SHALL have ports: stall_i in 6 (pipeline stall vector), flush_i in 1 (exception flush), llbit_clear_i in 1 (exception/eret clears LL bit).
REQ-004 SHALL have ports: bus_req_o out 1, bus_we_o out 1, bus_addr_o out 32, bus_sel_o out 4, bus_wdata_o out 32, bus_rdata_i in 32, bus_ack_i in 1: data-bus master.
REQ-005 SHALL have ports: wd_o out 5, wreg_o out 1, wdata_o out 32, hi_o out 32, lo_o out 32, whilo_o out 1 (to MEM/WB); stallreq_o out 1 (stall request).

Function
REQ-006 SHALL pass wd, hi, lo, whilo through combinationally; non-memory aluop passes wreg/wdata unchanged, no bus activity, stallreq_o=0.
REQ-007 SHALL implement FSM IDLE, REQ, DONE.
REQ-008 IDLE + memory op + !flush_i: bus_req_o=1 combinationally, stallreq_o=1, next state REQ.
REQ-009 REQ: bus_req_o/we/addr/sel/wdata held stable, stallreq_o=1 until bus_ack_i; on ack latch bus_rdata_i into internal register, next state DONE.
REQ-010 DONE: bus_req_o=0, stallreq_o=0, outputs formed from latched data; stay in DONE while stall_i[3]=1; go IDLE when stall_i[3]=0.
REQ-011 Minimum memory-op latency: request cycle + ack cycle + DONE cycle (3 cycles with ack on first REQ cycle).
REQ-012 bus_addr_o = {mem_addr_i[31:2],2'b00}; big-endian lanes: byte offset 0 -> sel 4'b1000, 3 -> 4'b0001; halfword addr[1]=0 -> 4'b1100, 1 -> 4'b0011 (addr[0] ignored); word -> 4'b1111.
REQ-013 Stores (SB/SH/SW) replicate reg2_i low byte/halfword across lanes; bus_we_o=1; wreg_o=0.
REQ-014 Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW whole word; wreg_o=wreg_i in DONE, 0 in IDLE/REQ.
REQ-015 flush_i in IDLE: no request, wreg_o=0, whilo_o=0.
REQ-016 flush_i in REQ: transaction completes (req held until ack), data discarded, next state IDLE (DONE skipped), wreg_o=0.
REQ-017 Unaligned addresses SHALL NOT raise exceptions here; low bits masked per REQ-012.

Reset
REQ-018 rst=0 SHALL force asynchronously: state IDLE, LL bit 0, latched data 0; all registered outputs 0; bus_req_o=0, stallreq_o=0.
REQ-019 Reset mid-REQ SHALL drop bus_req_o immediately; a late bus_ack_i after reset SHALL be ignored.

Configuration
REQ-020 Macro MEM_ACCESS_LLSC_EN defined: LL = LW plus LL bit set on DONE entry; SC with LL bit=1 performs SW, writes wdata_o=1, clears LL bit; SC with LL bit=0 issues no request, single cycle, wreg_o=1, wdata_o=0.
REQ-021 llbit_clear_i SHALL win over LL set in the same cycle.
REQ-022 Macro undefined: no LL bit; LL decoded as LW; SC issues no request, wreg_o=1, wdata_o=0.

Structure
REQ-023 aluop encodings, RegBus/RegAddrBus widths, zeroword, FSM state codes SHALL live in shared defines.v.
REQ-024 Lane selection/extension SHALL be a combinational sub-module mem_align; FSM and LL bit stay in mem_access.

Verification
REQ-025 LW addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF -> sel 4'b1111, stallreq 1 for 3 cycles, DONE wdata_o=0xDEADBEEF, wreg_o=1.
REQ-026 LB addr 0x103, rdata 0x112233F0 -> sel 4'b0001, wdata_o=0xFFFFFFF0; LBU same -> 0x000000F0.
REQ-027 SH addr 0x202, reg2 0x0000ABCD -> we=1, sel 4'b0011, bus_wdata_o=0xABCDABCD, wreg_o=0.
REQ-028 LL 0x300 then SC 0x300 (reg2 5) -> SC stores, wdata_o=1; SC repeated -> no request, wdata_o=0.
REQ-029 flush_i asserted during REQ, ack 1 cycle later -> req held to ack, no DONE, wreg_o=0, next op issues normally.
REQ-030 rst low during REQ -> bus_req_o=0 same cycle, state IDLE, late ack ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: bus widths, aluop encodings, FSM state codes.
// Optional LL/SC support in mem_access is enabled by defining MEM_ACCESS_LLSC_EN.
package mem_access_pkg;

    localparam int          REG_W      = 32;
    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_LL  = 8'hF0;
    localparam logic [7:0] OP_SC  = 8'hF8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic is_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: is_load = 1'b1;
            default:                                     is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // SC drives the bus exactly like SW once it is allowed to proceed
    function automatic logic is_write(input logic [7:0] op);
        is_write = is_store(op) || (op == OP_SC);
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: big-endian byte-lane select, store replication and load extension.
// Purely combinational; the FSM in mem_access chooses which operands it sees.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [7:0]       aluop_i,
    input  logic [1:0]       addr_lo_i,
    input  logic [REG_W-1:0] rdata_i,
    input  logic [REG_W-1:0] reg2_i,
    output logic [3:0]       sel_o,
    output logic [REG_W-1:0] wdata_o,
    output logic [REG_W-1:0] ldata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign half_s = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    // Byte lane picked by the low address bits, offset 0 is the MSB lane
    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[31:24];
            2'd1:    byte_s = rdata_i[23:16];
            2'd2:    byte_s = rdata_i[15:8];
            2'd3:    byte_s = rdata_i[7:0];
            default: byte_s = 8'h00;
        endcase
    end

    // Lane enables, store data and extended load data per operation
    always_comb begin
        sel_o   = 4'b0000;
        wdata_o = ZERO_WORD;
        ldata_o = ZERO_WORD;
        case (aluop_i)
            OP_LB: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                ldata_o = {{24{byte_s[7]}}, byte_s};
            end
            OP_LBU: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                ldata_o = {24'h00_0000, byte_s};
            end
            OP_SB: begin
                sel_o   = 4'b1000 >> addr_lo_i;
                wdata_o = {4{reg2_i[7:0]}};
            end
            OP_LH: begin
                sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                ldata_o = {{16{half_s[15]}}, half_s};
            end
            OP_LHU: begin
                sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                ldata_o = {16'h0000, half_s};
            end
            OP_SH: begin
                sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{reg2_i[15:0]}};
            end
            OP_LW, OP_LL: begin
                sel_o   = 4'b1111;
                ldata_o = rdata_i;
            end
            OP_SW, OP_SC: begin
                sel_o   = 4'b1111;
                wdata_o = reg2_i;
            end
            default: begin
                sel_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: data-bus master FSM (IDLE/REQ/DONE) with optional LL bit.
// Define MEM_ACCESS_LLSC_EN to enable LL/SC; otherwise LL acts as LW and SC always fails.
module mem_access
    import mem_access_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [REG_W-1:0]      hi_i,
    input  logic [REG_W-1:0]      lo_i,
    input  logic                  whilo_i,
    input  logic [7:0]            aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [5:0]            stall_i,
    input  logic                  flush_i,
    input  logic                  llbit_clear_i,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [REG_W-1:0]      bus_addr_o,
    output logic [3:0]            bus_sel_o,
    output logic [REG_W-1:0]      bus_wdata_o,
    input  logic [REG_W-1:0]      bus_rdata_i,
    input  logic                  bus_ack_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  whilo_o,
    output logic                  stallreq_o
);

    state_e           state_q;
    logic [7:0]       aluop_q;
    logic [REG_W-1:0] addr_q;
    logic [REG_W-1:0] reg2_q;
    logic [REG_W-1:0] rdata_q;
    logic             flushed_q;
    logic             llbit_s;
    logic             idle_s;
    logic             req_op_s;
    logic             sc_fail_s;
    logic             commit_s;
    logic [7:0]       al_op_s;
    logic [1:0]       al_off_s;
    logic [REG_W-1:0] al_reg2_s;
    logic [3:0]       al_sel_s;
    logic [REG_W-1:0] al_wdata_s;
    logic [REG_W-1:0] al_ldata_s;
    logic             unused_s;

    assign unused_s = ^{stall_i[5:4], stall_i[2:0], llbit_clear_i};

    assign idle_s    = (state_q == ST_IDLE);
    assign req_op_s  = is_load(aluop_i) || is_store(aluop_i) || ((aluop_i == OP_SC) && llbit_s);
    assign sc_fail_s = (aluop_i == OP_SC) && !llbit_s;
    assign commit_s  = (state_q == ST_REQ) && bus_ack_i && !flush_i && !flushed_q;

    assign wd_o = wd_i;
    assign hi_o = hi_i;
    assign lo_o = lo_i;

`ifdef MEM_ACCESS_LLSC_EN
    logic llbit_q;

    // LL bit: external clear has priority over the set on LL completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_q <= 1'b0;
        end else if (llbit_clear_i) begin
            llbit_q <= 1'b0;
        end else if (commit_s && (aluop_q == OP_LL)) begin
            llbit_q <= 1'b1;
        end else if (commit_s && (aluop_q == OP_SC)) begin
            llbit_q <= 1'b0;
        end
    end

    assign llbit_s = llbit_q;
`else
    assign llbit_s = 1'b0;
`endif

    // Outside IDLE the aligner sees the captured request so bus fields stay frozen
    assign al_op_s   = idle_s ? aluop_i         : aluop_q;
    assign al_off_s  = idle_s ? mem_addr_i[1:0] : addr_q[1:0];
    assign al_reg2_s = idle_s ? reg2_i          : reg2_q;

    mem_align u_align (
        .aluop_i   (al_op_s),
        .addr_lo_i (al_off_s),
        .rdata_i   (rdata_q),
        .reg2_i    (al_reg2_s),
        .sel_o     (al_sel_s),
        .wdata_o   (al_wdata_s),
        .ldata_o   (al_ldata_s)
    );

    // Bus FSM; a flush seen during REQ finishes the handshake and skips DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            aluop_q   <= OP_NOP;
            addr_q    <= ZERO_WORD;
            reg2_q    <= ZERO_WORD;
            rdata_q   <= ZERO_WORD;
            flushed_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_op_s && !flush_i) begin
                        state_q   <= ST_REQ;
                        aluop_q   <= aluop_i;
                        addr_q    <= mem_addr_i;
                        reg2_q    <= reg2_i;
                        flushed_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (flush_i) begin
                        flushed_q <= 1'b1;
                    end
                    if (bus_ack_i) begin
                        if (commit_s) begin
                            rdata_q <= bus_rdata_i;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (!stall_i[3]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus drive and MEM/WB results; the IDLE request is gated by rst so reset drops it at once
    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = ZERO_WORD;
        bus_sel_o   = 4'b0000;
        bus_wdata_o = ZERO_WORD;
        stallreq_o  = 1'b0;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        whilo_o     = whilo_i;
        case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    wreg_o  = 1'b0;
                    whilo_o = 1'b0;
                end else if (req_op_s && rst) begin
                    bus_req_o   = 1'b1;
                    bus_we_o    = is_write(aluop_i);
                    bus_addr_o  = {mem_addr_i[31:2], 2'b00};
                    bus_sel_o   = al_sel_s;
                    bus_wdata_o = al_wdata_s;
                    stallreq_o  = 1'b1;
                    wreg_o      = 1'b0;
                end else if (sc_fail_s) begin
                    wreg_o  = 1'b1;
                    wdata_o = ZERO_WORD;
                end else begin
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                end
            end
            ST_REQ: begin
                bus_req_o   = 1'b1;
                bus_we_o    = is_write(aluop_q);
                bus_addr_o  = {addr_q[31:2], 2'b00};
                bus_sel_o   = al_sel_s;
                bus_wdata_o = al_wdata_s;
                stallreq_o  = 1'b1;
                wreg_o      = 1'b0;
            end
            ST_DONE: begin
                if (aluop_q == OP_SC) begin
                    wreg_o  = wreg_i;
                    wdata_o = 32'h0000_0001;
                end else if (is_store(aluop_q)) begin
                    wreg_o  = 1'b0;
                    wdata_o = wdata_i;
                end else begin
                    wreg_o  = wreg_i;
                    wdata_o = al_ldata_s;
                end
            end
            default: begin
                stallreq_o = 1'b0;
            end
        endcase
    end

endmodule
